// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit.
//   SH_*     : 3-bit shift_type encoding, the same one the ALU shifters use
//   state_t  : control FSM states
//   is_illegal(): 110/111 are reserved encodings
package shift_pkg;

  localparam logic [2:0] SH_SLL = 3'b000;
  localparam logic [2:0] SH_SRL = 3'b001;
  localparam logic [2:0] SH_SLA = 3'b010;
  localparam logic [2:0] SH_SRA = 3'b011;
  localparam logic [2:0] SH_ROL = 3'b100;
  localparam logic [2:0] SH_ROR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [2:0] t);
    return t[2] & t[1];
  endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shift unit (combinational).
// Shifts data by amt positions, where amt is 0..STEP, as a chain of 1-bit steps.
//   data     : word to shift
//   amt      : number of positions for this cycle (never above STEP)
//   sh_type  : shift_type encoding
//   fill     : bit shifted in from the MSB for SRA
//   result   : shifted word
//   last_out : bit that left the word on the final 1-bit step (0 if amt==0)
//   sign_chg : SLA only; the MSB changed on at least one 1-bit step
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int AW    = 5
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    amt,
  input  logic [2:0]       sh_type,
  input  logic             fill,
  output logic [WIDTH-1:0] result,
  output logic             last_out,
  output logic             sign_chg
);

  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] nxt;

  // Modelling the shift as unit steps makes the carry and the SLA
  // sign-change flag fall out directly, with no special cases.
  always_comb begin
    w        = data;
    nxt      = data;
    last_out = 1'b0;
    sign_chg = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(amt)) begin
        nxt = w;
        case (sh_type)
          SH_SLL, SH_SLA: begin last_out = w[WIDTH-1]; nxt = {w[WIDTH-2:0], 1'b0};       end
          SH_SRL:         begin last_out = w[0];       nxt = {1'b0, w[WIDTH-1:1]};       end
          SH_SRA:         begin last_out = w[0];       nxt = {fill, w[WIDTH-1:1]};       end
          SH_ROL:         begin last_out = w[WIDTH-1]; nxt = {w[WIDTH-2:0], w[WIDTH-1]}; end
          SH_ROR:         begin last_out = w[0];       nxt = {w[0], w[WIDTH-1:1]};       end
          default:        begin last_out = 1'b0;       nxt = w;                          end
        endcase
        if (sh_type == SH_SLA && nxt[WIDTH-1] != w[WIDTH-1]) sign_chg = 1'b1;
        w = nxt;
      end
    end
    result = w;
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: accepts one operation over in_valid/in_ready,
// shifts at most STEP positions per cycle, and returns the result and flags over
// out_valid/out_ready.
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : request handshake (in_ready only in IDLE)
//   in0, in1, shift_type: operand, unsigned amount, operation
//   out_valid/out_ready : result handshake (held in DONE)
//   shift_result, carry_out, zero, overflow, err : result and flags
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [AMT_W-1:0] in1,
  input  logic [2:0]       shift_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shift_result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int LW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] work;
  logic [2:0]       typ;
  logic [AMT_W-1:0] rem;
  logic             fill;
  logic [AMT_W-1:0] amt_eff;
  logic [AMT_W-1:0] s;
  logic [WIDTH-1:0] step_res;
  logic             step_last;
  logic             step_chg;
  logic             illegal;

  assign illegal   = is_illegal(shift_type);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Rotates wrap modulo WIDTH; plain shifts saturate at WIDTH.
  always_comb begin
    amt_eff = in1;
    if (shift_type == SH_ROL || shift_type == SH_ROR) amt_eff = {1'b0, in1[LW-1:0]};
    else if (in1 > AMT_W'(WIDTH))                     amt_eff = AMT_W'(WIDTH);
  end

  assign s = (rem > AMT_W'(STEP)) ? AMT_W'(STEP) : rem;

  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .AW(AMT_W)) u_step (
    .data     (work),
    .amt      (s),
    .sh_type  (typ),
    .fill     (fill),
    .result   (step_res),
    .last_out (step_last),
    .sign_chg (step_chg)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid) state_nx = (illegal || amt_eff == '0) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (rem == s) state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work         <= '0;
      typ          <= SH_SLL;
      rem          <= '0;
      fill         <= 1'b0;
      shift_result <= '0;
      carry_out    <= 1'b0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          work      <= in0;
          typ       <= shift_type;
          rem       <= amt_eff;
          fill      <= in0[WIDTH-1];
          carry_out <= 1'b0;
          overflow  <= 1'b0;
          err       <= illegal;
          // Zero-length and illegal operations skip BUSY, so publish now.
          if (illegal) begin
            shift_result <= '0;
            zero         <= 1'b1;
          end else if (amt_eff == '0) begin
            shift_result <= in0;
            zero         <= (in0 == '0);
          end
        end
        ST_BUSY: begin
          work      <= step_res;
          rem       <= rem - s;
          carry_out <= step_last;
          overflow  <= overflow | step_chg;
          if (rem == s) begin
            shift_result <= step_res;
            zero         <= (step_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
module tb_shift_unit_seq;

  localparam int W  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in0 = '0;
  logic [AW-1:0] in1 = '0;
  logic [2:0]    shift_type = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  shift_result;
  logic          carry_out, zero, overflow, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_unit_seq #(.WIDTH(16), .STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .shift_type(shift_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .shift_result(shift_result), .carry_out(carry_out), .zero(zero),
    .overflow(overflow), .err(err)
  );

  typedef struct packed {
    logic [15:0] res;
    logic        c, z, o, e;
    logic [7:0]  lat;
  } exp_t;

  // Reference: whole-word arithmetic on the operation's definition.
  function automatic exp_t model(input logic [15:0] a, input logic [4:0] b, input logic [2:0] t);
    exp_t e;
    int amt, top;
    logic [31:0] x;
    e = '0;
    if (t >= 3'd6) begin
      e.e = 1'b1; e.z = 1'b1; e.lat = 8'd1;
      return e;
    end
    amt = (t < 3'd4) ? ((b > 5'd16) ? 16 : int'(b)) : int'(b) % 16;
    case (t)
      3'd0, 3'd2: begin
        x = {16'h0, a} << amt; e.res = x[15:0];
        if (amt > 0) e.c = a[16-amt];
      end
      3'd1: begin
        x = {16'h0, a} >> amt; e.res = x[15:0];
        if (amt > 0) e.c = a[amt-1];
      end
      3'd3: begin
        x = {{16{a[15]}}, a};
        x = $signed(x) >>> amt; e.res = x[15:0];
        if (amt > 0) e.c = a[amt-1];
      end
      3'd4: begin
        x = {a, a} << amt; e.res = x[31:16];
        if (amt > 0) e.c = e.res[0];
      end
      default: begin
        x = {a, a} >> amt; e.res = x[15:0];
        if (amt > 0) e.c = e.res[15];
      end
    endcase
    if (t == 3'd2 && amt > 0) begin
      if (amt >= 16) e.o = (a != 16'h0);
      else begin
        top = int'(a) >> (15 - amt);
        e.o = !(top == 0 || top == ((1 << (amt + 1)) - 1));
      end
    end
    e.z   = (e.res == 16'h0);
    e.lat = (amt == 0) ? 8'd1 : 8'(1 + (amt + 3) / 4);
    return e;
  endfunction

  // Drives one request from IDLE and counts edges (accept edge included)
  // until out_valid; gives up after 40.
  task automatic issue(input logic [15:0] a, input logic [4:0] b, input logic [2:0] t,
                       output int lat);
    @(negedge clk);
    in0 = a; in1 = b; shift_type = t; in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic release_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, shift_result, carry_out, zero, overflow, err} !== {1'b1, 1'b0, 16'h0, 4'b0}) begin
      n_bad++;
      $display("FAIL reset: rdy=%b vld=%b res=%h c=%b z=%b o=%b e=%b, want rdy=1 vld=0 res=0000 flags=0",
               in_ready, out_valid, shift_result, carry_out, zero, overflow, err);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [8] = '{16'h8F00, 16'h8001, 16'h1234, 16'h1234, 16'h4000, 16'hC000, 16'hFFFF, 16'h5555};
    logic [4:0]  tb [8] = '{5'd4, 5'd20, 5'd20, 5'd0, 5'd1, 5'd1, 5'd16, 5'd3};
    logic [2:0]  tt [8] = '{3'd3, 3'd1, 3'd4, 3'd5, 3'd2, 3'd2, 3'd2, 3'd7};
    logic [15:0] er [8] = '{16'hF8F0, 16'h0000, 16'h2341, 16'h1234, 16'h8000, 16'h8000, 16'h0000, 16'h0000};
    // flags packed as {carry, zero, overflow, err}
    logic [3:0]  ef [8] = '{4'b0000, 4'b1100, 4'b1000, 4'b0000, 4'b0010, 4'b1000, 4'b1110, 4'b0101};
    int          el [8] = '{2, 5, 2, 1, 2, 2, 5, 1};
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue(ta[i], tb[i], tt[i], lat);
      n_cmp++;
      if (lat !== el[i] || shift_result !== er[i] || {carry_out, zero, overflow, err} !== ef[i]) begin
        n_bad++;
        $display("FAIL directed[%0d]: lat=%0d res=%h czoe=%b, want lat=%0d res=%h czoe=%b",
                 i, lat, shift_result, {carry_out, zero, overflow, err}, el[i], er[i], ef[i]);
      end
      release_result();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL directed_release[%0d]: rdy=%b vld=%b, want rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(16'h0001, 5'd15, 3'd0, lat);
    n_cmp++;
    if (lat !== 5 || shift_result !== 16'h8000) begin
      n_bad++;
      $display("FAIL bp_result: lat=%0d res=%h, want lat=5 res=8000", lat, shift_result);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in0 = 16'hAAAA; in1 = 5'd1; shift_type = 3'd1;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || shift_result !== 16'h8000 || carry_out !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h c=%b, want vld=1 rdy=0 res=8000 c=0",
                 i, out_valid, in_ready, shift_result, carry_out);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_no_accept: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    issue(16'h00F0, 5'd0, 3'd0, lat);
    release_result();
    @(negedge clk);
    in0 = 16'hFFFF; in1 = 5'd16; shift_type = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_state: rdy=%b vld=%b, want rdy=0 vld=0", in_ready, out_valid);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || shift_result !== 16'h0 || carry_out !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_reset: rdy=%b vld=%b res=%h c=%b, want rdy=1 vld=0 res=0000 c=0",
               in_ready, out_valid, shift_result, carry_out);
    end
    @(negedge clk); rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_discard: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_illegal();
    int lat;
    issue(16'hBEEF, 5'd9, 3'd6, lat);
    n_cmp++;
    if (lat !== 1 || shift_result !== 16'h0 || {carry_out, zero, overflow, err} !== 4'b0101) begin
      n_bad++;
      $display("FAIL illegal: lat=%0d res=%h czoe=%b, want lat=1 res=0000 czoe=0101",
               lat, shift_result, {carry_out, zero, overflow, err});
    end
    release_result();
    // err must clear on the next legal accept
    issue(16'h0003, 5'd1, 3'd0, lat);
    n_cmp++;
    if (err !== 1'b0 || shift_result !== 16'h0006 || lat !== 2) begin
      n_bad++;
      $display("FAIL illegal_clear: err=%b res=%h lat=%0d, want err=0 res=0006 lat=2", err, shift_result, lat);
    end
    release_result();
  endtask

  task automatic test_random();
    exp_t e;
    int lat, hold;
    logic [15:0] a;
    logic [4:0]  b;
    logic [2:0]  t;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      b = 5'($urandom_range(0, 31));
      t = 3'($urandom_range(0, 7));
      if (i % 5 == 0) a = 16'($urandom_range(0, 1)) ? 16'hFFFF : 16'h0000;
      e = model(a, b, t);
      issue(a, b, t, lat);
      n_cmp++;
      if (lat !== int'(e.lat) || shift_result !== e.res ||
          {carry_out, zero, overflow, err} !== {e.c, e.z, e.o, e.e}) begin
        n_bad++;
        $display("FAIL random[%0d] t=%0d a=%h b=%0d: lat=%0d res=%h czoe=%b, want lat=%0d res=%h czoe=%b",
                 i, t, a, b, lat, shift_result, {carry_out, zero, overflow, err},
                 e.lat, e.res, {e.c, e.z, e.o, e.e});
      end
      hold = $urandom_range(0, 2);
      repeat (hold) @(posedge clk);
      #1;
      if (hold > 0) begin
        n_cmp++;
        if (out_valid !== 1'b1 || shift_result !== e.res) begin
          n_bad++;
          $display("FAIL random_hold[%0d]: vld=%b res=%h, want vld=1 res=%h", i, out_valid, shift_result, e.res);
        end
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
Parametrised, multi-cycle successor to the 16-bit combinational shifting unit. It accepts one operation at a time over a valid/ready handshake and performs it iteratively, shifting at most STEP bit positions per cycle. It returns the result with carry/zero/overflow/error flags over a second valid/ready handshake. It sits beside the ALU arithmetic units and is selected by the same 3-bit shift_type encoding.

Parameters:
WIDTH, 16, data width in bits; must be ≥4 and a power of 2.
STEP, 4, maximum bit positions shifted per cycle; must be a power of 2 with 1 ≤ STEP ≤ WIDTH.
AMT_W, $clog2(WIDTH)+1, width of the shift-amount port (derived; do not override).

Ports:
clk  in  1  single clock; all state changes on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request (high only in IDLE).
in0  in  WIDTH  operand to shift.
in1  in  AMT_W  shift amount, unsigned.
shift_type  in  3  000 SLL, 001 SRL, 010 SLA, 011 SRA, 100 ROL, 101 ROR, 110/111 illegal.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
shift_result  out  WIDTH  result.
carry_out  out  1  last bit shifted or rotated out.
zero  out  1  shift_result == 0.
overflow  out  1  SLA only: sign bit changed during any 1-bit step.
err  out  1  illegal shift_type.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE; in_ready=1; out_valid=0; shift_result=0; carry_out=0; zero=0; overflow=0; err=0. Reset wins over every other event, including mid-BUSY and mid-DONE. An in-flight operation is discarded with no output.
- Accept: in IDLE with in_valid=1, capture in0, shift_type and the effective amount amt_eff. Clear carry, overflow and err.
  - amt_eff for SLL/SRL/SLA/SRA is min(in1, WIDTH).
  - amt_eff for ROL/ROR is in1 mod WIDTH.
- Transition at accept: if amt_eff==0 or shift_type is illegal, go to DONE; otherwise go to BUSY with rem=amt_eff.
- BUSY: each cycle shift by s=min(rem, STEP) and set rem -= s. Go to DONE when the new rem==0. in_ready=0 throughout.
- Latency: out_valid rises 1+ceil(amt_eff/STEP) cycles after the accept edge. amt_eff==0 or an illegal type gives latency 1.
- DONE: out_valid=1; shift_result and all flags are stable while out_ready=0. When out_ready=1, go to IDLE. in_ready rises in the cycle after the handshake; no same-cycle turnaround.
- in_valid outside IDLE is ignored; the request must be held by the producer.
- Fill rules:
  - SLL/SLA: zero fill from bit 0.
  - SRL: zero fill from the MSB.
  - SRA: fill with the captured in0[WIDTH-1]; applies to both sign values.
  - ROL/ROR: true rotation, with no fill.
- carry_out: the bit that left the word on the final 1-bit position.
  - SLL/SLA: in0[WIDTH-amt_eff].
  - SRL/SRA: in0[amt_eff-1].
  - ROL: shift_result[0].
  - ROR: shift_result[WIDTH-1].
  - Forced to 0 when amt_eff==0 or err=1.
- overflow: only for SLA; 0 for every other type. Equivalent to: the top min(amt_eff+1, WIDTH) bits of in0 are not all equal. At amt_eff==WIDTH it reduces to in0!=0.
- Illegal type (110/111): shift_result=0, err=1, zero=1, carry_out=0, overflow=0.
- zero: registered together with shift_result when entering DONE.

Decomposition:
- Package shift_pkg holds:
  - shift_type localparams: SH_SLL, SH_SRL, SH_SLA, SH_SRA, SH_ROL, SH_ROR.
  - State encoding: ST_IDLE, ST_BUSY, ST_DONE.
- Sub-module shift_step: combinational; shifts a WIDTH-bit word by 0..STEP positions for a given type and fill bit. Returns the shifted word, the last bit out and a sign-changed flag.
- Top level holds the FSM, the rem counter and the output registers.

Test Plan:
1. WIDTH=16, STEP=4. SRA in0=0x8F00, in1=4 -> 0xF8F0, carry_out=0, overflow=0; out_valid 2 cycles after accept.
2. SRL in0=0x8001, in1=20 (clamped to 16) -> 0x0000, zero=1, carry_out=1; latency 5.
3. ROL in0=0x1234, in1=20 (eff 4) -> 0x2341, carry_out=1; latency 2. ROR 0x1234 by 0 -> 0x1234, carry_out=0; latency 1.
4. SLA 0x4000 by 1 -> 0x8000, overflow=1. SLA 0xC000 by 1 -> 0x8000, overflow=0. SLA 0xFFFF by 16 -> 0x0000, overflow=1.
5. Backpressure: SLL 0x0001 by 15, hold out_ready=0 for 3 cycles with in_valid=1 -> shift_result=0x8000 stable, in_ready=0, new request not accepted. in_ready=1 in the cycle after out_ready=1.
6. rst=1 during BUSY -> next cycle IDLE, out_valid=0, shift_result=0. Then shift_type=110 -> shift_result=0, err=1, zero=1; latency 1.
